prbs15_pattern_checker: RTL
===========================

# prbs15_pattern_checker

Receive-side counterpart of the PRBS-15 pattern generator. It consumes the generator's byte stream, which is a 32-bit header word repeated `n` times followed by a continuous PRBS-15 byte stream. It detects the header repetitions, self-seeds a local PRBS-15 LFSR from the stream, then checks every following byte bit-for-bit and reports lock status and an error count. It sits at the end of the pattern-detector link, facing the generator's `out` bus.

## Interface
- `BYTES_PER_WORD`, 4: header word length in bytes (fixed; `seq` is 32 bits).
- `LOSS_THRESH`, 4: number of consecutive errored bytes in CHECK that drops lock.
- `clk`  in  1  rising-edge clock.
- `rst`  in  1  synchronous, active-high reset.
- `din`  in  8  received byte (the generator's `out`).
- `din_valid`  in  1  `din` is meaningful this cycle; all state advances only on valid cycles.
- `seq`  in  32  expected header word, sent MSB byte first (`seq[31:24]` first).
- `n`  in  8  expected header repetitions; 0 is treated as 1.
- `pattern_found`  out  1  one-cycle pulse when the n-th header repetition completes.
- `prbs_locked`  out  1  high while in CHECK.
- `byte_err`  out  1  one-cycle pulse when a checked byte has one or more bit errors.
- `err_cnt`  out  16  accumulated bit errors, saturating at 0xFFFF.

## Operation
- PRBS-15 polynomial is x^15+x^14+1. Bits are serialized MSB first within each byte. Stream rule: b[k] = b[k-15] ^ b[k-14].
- LFSR state `s[14:0]`, with `s[14]` the oldest bit. Next bit = `s[14]^s[13]`, and `s <= {s[13:0], next}`. One byte advances the state 8 steps.
- **HUNT** (reset state). Byte index `bi` runs 0..3 and repetition counter `rc` runs 0..n-1.
  - If `din` equals `seq` byte `bi`, advance `bi`. When `bi` wraps from 3 to 0, increment `rc`.
  - On a mismatch, set `bi` and `rc` to 0 and re-evaluate the same byte against byte 0. If it matches, `bi` becomes 1.
  - When repetition n completes: pulse `pattern_found` and go to SEED.
  - `seq` and `n` are sampled only in HUNT. Changes in other states are ignored until the next HUNT.
- **SEED**. Capture 2 valid bytes, B0 then B1. Load `s = {B0[6:0], B1}`. Go to CHECK.
- **CHECK**.
  - For each valid byte, generate 8 expected bits from `s` (first generated bit is `exp[7]`).
  - Compute `x = din ^ exp`. If `x != 0`, pulse `byte_err`.
  - Add popcount(`x`) (0..8) to `err_cnt`, saturating.
  - `s` advances using the expected bits, not the received bits, so errors do not propagate.
  - An error-run counter counts consecutive errored bytes and clears on any clean byte. When it reaches `LOSS_THRESH`, drop `prbs_locked` and go to SEED to reseed. `err_cnt` is kept.
- `err_cnt` clears only on `rst`.
- Invalid cycles (`din_valid=0`) hold all state. Pulse outputs are 0 on those cycles.

## Timing
- All outputs are registered. The response to a valid byte at edge k appears after edge k, i.e. one-cycle latency.
- `pattern_found` is high for exactly one cycle, following the 4·n-th matching header byte.
- `prbs_locked` rises in the cycle after the second SEED byte is accepted. It falls in the cycle after the `LOSS_THRESH`-th consecutive errored byte.
- Reset values: `pattern_found=0`, `prbs_locked=0`, `byte_err=0`, `err_cnt=0`, state=HUNT, `bi=0`, `rc=0`, `s=0`, error-run counter 0.
- `rst` asserted mid-operation in any state returns the block to the reset values at the next edge. `rst` has priority over `din_valid`.
- Saturation: when `err_cnt` + popcount exceeds 0xFFFF, the result is 0xFFFF. There is no wrap.

## Test plan
- **Header detect.** `seq=32'hABCDEF23`, `n=5`. Send AB CD EF 23 ×5, one byte per cycle. Required: `pattern_found` pulses exactly once, one cycle after the 20th byte; no pulse after ×4 repetitions.
- **Header restart.** Send AB CD AB CD EF 23 … with `n=1`. Required: the mismatch at byte 3 restarts the hunt, that same AB is accepted as byte 0, and `pattern_found` pulses after the final 23.
- **Clean PRBS.** After the header, send FF FF (seed `s=0x7FFF`), then 00, 02. Required: `prbs_locked=1` after the second FF; no `byte_err`; `err_cnt=0`.
- **Bit error.** Same as the clean PRBS case, but send 03 instead of 02. Required: one `byte_err` pulse and `err_cnt=1`; lock is held.
- **Loss of lock.** In CHECK, send 4 consecutive bytes of wrong data. Required: `prbs_locked` falls after the 4th byte; the block reseeds from the next 2 bytes, then relocks.
- **Reset and stall.** Toggle `din_valid` low mid-header and confirm state is held. Assert `rst` in CHECK. Required: all outputs 0 next cycle, and the block hunts again from the header.

Source files
------------

// File: rtl/prbs15_pattern_checker.sv
// PRBS-15 (x^15 + x^14 + 1) receive checker.
// Hunts for n repetitions of a 32-bit header word, then self-seeds a local
// LFSR from the next two bytes and compares every following byte bit for bit.
// Reports lock state, a per-byte error pulse and a saturating bit-error count.
module prbs15_pattern_checker #(
  parameter int BYTES_PER_WORD = 4,
  parameter int LOSS_THRESH    = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  din,
  input  logic        din_valid,
  input  logic [31:0] seq,
  input  logic [7:0]  n,
  output logic        pattern_found,
  output logic        prbs_locked,
  output logic        byte_err,
  output logic [15:0] err_cnt
);

  localparam int BI_W  = (BYTES_PER_WORD > 1) ? $clog2(BYTES_PER_WORD) : 1;
  localparam int RUN_W = $clog2(LOSS_THRESH + 1);
  localparam logic [BI_W-1:0]  BI_LAST = BI_W'(BYTES_PER_WORD - 1);
  localparam logic [RUN_W-1:0] RUN_LIM = RUN_W'(LOSS_THRESH);

  typedef enum logic [1:0] {
    HUNT  = 2'd0,
    SEED  = 2'd1,
    CHECK = 2'd2
  } state_t;

  state_t           state;
  logic [BI_W-1:0]  bi;
  logic [7:0]       rc;
  logic [14:0]      s;
  logic [RUN_W-1:0] err_run;
  logic             seed_have;
  logic [6:0]       seed_lo;

  logic [7:0]       n_eff;
  logic [7:0]       rc_inc;
  logic [RUN_W-1:0] run_inc;
  logic             hit;
  logic             hit0;
  logic [7:0]       exp_byte;
  logic [14:0]      s_adv;
  logic [7:0]       err_bits;
  logic [3:0]       bit_errs;

  // Header byte idx of seq, most significant byte first.
  function automatic logic [7:0] seq_byte(input logic [31:0] w, input logic [BI_W-1:0] idx);
    logic [31:0] sh;
    sh = w << (8 * int'(idx));
    return sh[31:24];
  endfunction

  // Eight LFSR steps; returns {expected byte (first bit in [7]), next state}.
  function automatic logic [22:0] prbs_step8(input logic [14:0] st);
    logic [14:0] t;
    logic [7:0]  e;
    logic        nb;
    t = st;
    e = '0;
    for (int i = 0; i < 8; i++) begin
      nb       = t[14] ^ t[13];
      e[7 - i] = nb;
      t        = {t[13:0], nb};
    end
    return {e, t};
  endfunction

  // Number of set bits in a byte.
  function automatic logic [3:0] popcount8(input logic [7:0] v);
    logic [3:0] c;
    c = '0;
    for (int i = 0; i < 8; i++) c = c + {3'b000, v[i]};
    return c;
  endfunction

  // Accumulate with clamp at all-ones instead of wrapping.
  function automatic logic [15:0] sat_add16(input logic [15:0] a, input logic [3:0] b);
    logic [16:0] sum;
    sum = {1'b0, a} + {13'd0, b};
    return sum[16] ? 16'hFFFF : sum[15:0];
  endfunction

  // Header match, expected PRBS byte and error popcount for the current input.
  always_comb begin
    n_eff             = (n == 8'd0) ? 8'd1 : n;
    rc_inc            = rc + 8'd1;
    run_inc           = err_run + RUN_W'(1);
    hit               = (din == seq_byte(seq, bi));
    hit0              = (din == seq_byte(seq, '0));
    {exp_byte, s_adv} = prbs_step8(s);
    err_bits          = din ^ exp_byte;
    bit_errs          = popcount8(err_bits);
  end

  // Control FSM, LFSR state, error accounting and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= HUNT;
      bi            <= '0;
      rc            <= '0;
      s             <= '0;
      err_run       <= '0;
      seed_have     <= 1'b0;
      pattern_found <= 1'b0;
      prbs_locked   <= 1'b0;
      byte_err      <= 1'b0;
      err_cnt       <= '0;
    end else begin
      pattern_found <= 1'b0;
      byte_err      <= 1'b0;
      if (din_valid) begin
        case (state)
          HUNT: begin
            if (hit) begin
              if (bi == BI_LAST) begin
                bi <= '0;
                if (rc_inc >= n_eff) begin
                  rc            <= '0;
                  pattern_found <= 1'b1;
                  seed_have     <= 1'b0;
                  state         <= SEED;
                end else begin
                  rc <= rc_inc;
                end
              end else begin
                bi <= bi + BI_W'(1);
              end
            end else begin
              // A broken header may itself start a new one.
              rc <= '0;
              bi <= hit0 ? BI_W'(1) : '0;
            end
          end
          SEED: begin
            if (!seed_have) begin
              seed_have <= 1'b1;
            end else begin
              s           <= {seed_lo, din};
              seed_have   <= 1'b0;
              err_run     <= '0;
              prbs_locked <= 1'b1;
              state       <= CHECK;
            end
          end
          CHECK: begin
            // Advance on expected bits so a line error never corrupts the reference.
            s       <= s_adv;
            err_cnt <= sat_add16(err_cnt, bit_errs);
            if (err_bits != 8'd0) begin
              byte_err <= 1'b1;
              if (run_inc >= RUN_LIM) begin
                err_run     <= '0;
                seed_have   <= 1'b0;
                prbs_locked <= 1'b0;
                state       <= SEED;
              end else begin
                err_run <= run_inc;
              end
            end else begin
              err_run <= '0;
            end
          end
          default: state <= HUNT;
        endcase
      end
    end
  end

  // First seed byte; only its low 7 bits reach the 15-bit LFSR.
  always_ff @(posedge clk) begin
    if (din_valid && state == SEED && !seed_have) seed_lo <= din[6:0];
  end

endmodule
